// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment value display.
//   - state_e    : conversion FSM states (IDLE, CONVERT, UPDATE)
//   - BCD_W      : width of one BCD digit
//   - SEG_DIGIT  : active-low segment patterns for digits 0..9 (bit0=A .. bit6=G)
//   - SEG_BLANK  : all segments off
//   - SEG_E      : letter "E", shown on both digits when the value exceeds 99
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_e;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern.
//   digit_i : 4-bit BCD digit
//   seg_o   : segment pattern, bit0=A .. bit6=G, 0 = segment lit;
//             codes 10..15 show nothing
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [6:0]       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0: seg_o = SEG_DIGIT[0];
            4'd1: seg_o = SEG_DIGIT[1];
            4'd2: seg_o = SEG_DIGIT[2];
            4'd3: seg_o = SEG_DIGIT[3];
            4'd4: seg_o = SEG_DIGIT[4];
            4'd5: seg_o = SEG_DIGIT[5];
            4'd6: seg_o = SEG_DIGIT[6];
            4'd7: seg_o = SEG_DIGIT[7];
            4'd8: seg_o = SEG_DIGIT[8];
            4'd9: seg_o = SEG_DIGIT[9];
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_value_display.sv
// Two-digit seven-segment display of an 8-bit unsigned value.
// A strobed value is converted to BCD by double dabble (one bit per cycle),
// then committed to the display registers. Values above 99 show a blinking "EE"
// and raise overflow.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   value_in    : value to display, sampled with value_valid while idle
//   value_valid : one-cycle strobe, ignored while busy
//   busy        : conversion in progress
//   seg_tens    : tens digit segments, active-low, bit0=A .. bit6=G
//   seg_ones    : ones digit segments, same encoding
//   overflow    : last committed value was greater than 99
module seg7_value_display
    import seg7_pkg::*;
#(
    parameter int BLINK_TICKS   = 12500000,
    parameter bit LEADING_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value_in,
    input  logic       value_valid,
    output logic       busy,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_ones,
    output logic       overflow
);

    localparam int               CNT_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_TICKS - 1);

    state_e             state_q,     state_d;
    logic [7:0]         shift_q,     shift_d;
    logic [11:0]        bcd_q,       bcd_d;
    logic [2:0]         iter_q,      iter_d;
    logic [6:0]         seg_tens_q,  seg_tens_d;
    logic [6:0]         seg_ones_q,  seg_ones_d;
    logic               overflow_q,  overflow_d;
    logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               blink_on_q,  blink_on_d;

    // Add-3 correction for tens and ones. The hundreds nibble never exceeds 2
    // for an 8-bit input, so it is shifted without correction.
    logic [7:0] bcd_adj;
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_adj
            assign bcd_adj[gi*BCD_W +: BCD_W] =
                (bcd_q[gi*BCD_W +: BCD_W] >= 4'd5) ? bcd_q[gi*BCD_W +: BCD_W] + 4'd3
                                                   : bcd_q[gi*BCD_W +: BCD_W];
        end
    endgenerate

    logic [6:0] dec_tens, dec_ones;

    bcd_to_seg7 u_dec_tens (
        .digit_i (bcd_q[7:4]),
        .seg_o   (dec_tens)
    );

    bcd_to_seg7 u_dec_ones (
        .digit_i (bcd_q[3:0]),
        .seg_o   (dec_ones)
    );

    always_comb begin
        logic commit;
        state_d     = state_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        iter_d      = iter_q;
        seg_tens_d  = seg_tens_q;
        seg_ones_d  = seg_ones_q;
        overflow_d  = overflow_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (value_valid) begin
                    shift_d = value_in;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {bcd_q[10:8], bcd_adj, shift_q, 1'b0};
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                commit = 1'b1;
                if (bcd_q[11:8] != 4'd0) begin
                    overflow_d = 1'b1;
                    seg_tens_d = SEG_E;
                    seg_ones_d = SEG_E;
                end else begin
                    overflow_d = 1'b0;
                    seg_ones_d = dec_ones;
                    seg_tens_d = (LEADING_BLANK && bcd_q[7:4] == 4'd0) ? SEG_BLANK : dec_tens;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Blink timing restarts at every commit so the first half-period is full.
        if (commit || !overflow_q) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == CNT_MAX) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            iter_q      <= '0;
            seg_tens_q  <= SEG_BLANK;
            seg_ones_q  <= SEG_BLANK;
            overflow_q  <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            iter_q      <= iter_d;
            seg_tens_q  <= seg_tens_d;
            seg_ones_q  <= seg_ones_d;
            overflow_q  <= overflow_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;
    assign seg_tens = blink_on_q ? seg_tens_q : SEG_BLANK;
    assign seg_ones = blink_on_q ? seg_ones_q : SEG_BLANK;

endmodule
